adsr_envelope: RTL

- Sits directly downstream of the per-note sinusoid generator and upstream of the mixer/DAC path.
- Applies an attack/decay/sustain/release amplitude envelope, keyed by a note gate, to the signed sample stream.
- Envelope advances one step per accepted sample, so envelope timing is measured in sample periods.
- Valid/ready handshake on both sides, with one registered output stage.

---
 rtl/adsr_envelope.sv | 94 +++++++++
 1 files changed

// File: rtl/adsr_envelope.sv
// adsr_envelope: gate-keyed ADSR amplitude envelope on a valid/ready sample stream, one output register.
// Define ADSR_ENVELOPE_ROUND_EN to round the scaled sample half up instead of flooring it.
module adsr_envelope #(
  parameter int width_p         = 12,
  parameter int env_width_p     = 8,
  parameter int attack_step_p   = 16,
  parameter int decay_step_p    = 4,
  parameter int sustain_level_p = 192,
  parameter int release_step_p  = 2
) (
  input  logic                      clk_i,
  input  logic                      reset_i,
  input  logic                      gate_i,
  input  logic                      valid_i,
  input  logic signed [width_p-1:0] data_i,
  output logic                      ready_o,
  output logic                      valid_o,
  output logic signed [width_p-1:0] data_o,
  input  logic                      ready_i,
  output logic                      busy_o
);
  localparam int lw = env_width_p + 1;
  localparam int pw = width_p + env_width_p + 1;
  localparam logic [lw-1:0] max_l = lw'((1 << env_width_p) - 1);
  localparam logic [lw-1:0] atk_l = lw'(attack_step_p);
  localparam logic [lw-1:0] dec_l = lw'(decay_step_p);
  localparam logic [lw-1:0] sus_l = lw'(sustain_level_p);
  localparam logic [lw-1:0] rel_l = lw'(release_step_p);
  localparam logic [env_width_p-1:0] max_n = env_width_p'((1 << env_width_p) - 1);
  localparam logic [env_width_p-1:0] sus_n = env_width_p'(sustain_level_p);
`ifdef ADSR_ENVELOPE_ROUND_EN
  localparam logic signed [pw-1:0] rnd = pw'(1 << (env_width_p - 1));
`else
  localparam logic signed [pw-1:0] rnd = '0;
`endif
  typedef enum logic [2:0] {idle_s, attack_s, decay_s, sustain_s, release_s} state_t;
  state_t state, state_n;
  logic [env_width_p-1:0] level, level_n;
  logic [lw-1:0] lvl_x, up;
  logic gate_q, acc, rise, fall;
  logic signed [pw-1:0] prod;
  assign ready_o = ~valid_o | ready_i;
  assign acc     = valid_i & ready_o;
  assign rise    = gate_i & ~gate_q;
  assign fall    = ~gate_i & gate_q;
  assign busy_o  = state != idle_s;
  assign lvl_x   = {1'b0, level};
  assign up      = lvl_x + atk_l;
  assign prod    = pw'(data_i) * pw'($signed({1'b0, level})) + rnd;
  // Gate edges take the cycle: the level only moves on an accepted sample with no edge.
  always_comb begin
    state_n = state;
    level_n = level;
    if (rise)
      state_n = attack_s;
    else if (fall)
      state_n = (state == idle_s || state == release_s) ? state : release_s;
    else if (acc)
      case (state)
        attack_s: begin
          level_n = up >= max_l ? max_n : env_width_p'(up);
          state_n = up >= max_l ? decay_s : attack_s;
        end
        decay_s: begin
          level_n = lvl_x <= sus_l ? level : lvl_x <= sus_l + dec_l ? sus_n : env_width_p'(lvl_x - dec_l);
          state_n = lvl_x <= sus_l + dec_l ? sustain_s : decay_s;
        end
        sustain_s: level_n = sus_n;
        release_s: begin
          level_n = lvl_x <= rel_l ? '0 : env_width_p'(lvl_x - rel_l);
          state_n = lvl_x <= rel_l ? idle_s : release_s;
        end
        default: level_n = '0;
      endcase
  end
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state   <= idle_s;
      level   <= '0;
      gate_q  <= 1'b0;
      valid_o <= 1'b0;
      data_o  <= '0;
    end else begin
      state  <= state_n;
      level  <= level_n;
      gate_q <= gate_i;
      if (acc) begin
        valid_o <= 1'b1;
        data_o  <= width_p'(prod >>> env_width_p);
      end else if (ready_i)
        valid_o <= 1'b0;
    end
  end
endmodule
